// File: rtl/execute_cycle.sv
// execute_cycle: RV32 execute stage with operand forwarding, ALU, branch resolve and E/M register
module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);
    logic [XLEN-1:0] src_a, src_b, write_data, alu_result;

    // Forwarding muxes (select 11 falls back to the register value) and immediate select
    always_comb begin
        src_a      = ForwardAE == 2'b01 ? ResultW : ForwardAE == 2'b10 ? ALUResultM : RD1_E;
        write_data = ForwardBE == 2'b01 ? ResultW : ForwardBE == 2'b10 ? ALUResultM : RD2_E;
        src_b      = ALUSrcE ? Imm_Ext_E : write_data;
    end

    // ALU; arithmetic wraps, only the zero result feeds branch resolution
    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            3'b110:  alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            default: alu_result = src_a << src_b[4:0];
        endcase
    end

    // Redirect fetch on taken BEQ or on JAL; target ignores forwarding
    always_comb begin
        PCSrcE    = (BranchE & (alu_result == '0)) | (ResultSrcE == 2'b10);
        PCTargetE = PCE + Imm_Ext_E;
    end

    // E/M pipeline register, cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= write_data;
            PCPlus4M   <= PCPlus4E;
        end
    end
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed vectors with queued expectations checked by separate monitors
module tb_execute_cycle;
    logic        clk, rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, BranchE;
    logic [2:0]  ALUControlE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic        PCSrcE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;

    typedef struct {
        logic        pcsrc;
        logic [31:0] tgt;
    } exp_c_t;

    typedef struct {
        logic        rw, mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4;
    } exp_m_t;

    exp_c_t cq[$];
    exp_m_t mq[$];
    int compared = 0;
    int mismatched = 0;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, " RegWriteM"}, 32'(RegWriteM), 32'd0);
        chk({tag, " MemWriteM"}, 32'(MemWriteM), 32'd0);
        chk({tag, " ResultSrcM"}, 32'(ResultSrcM), 32'd0);
        chk({tag, " RD_M"}, 32'(RD_M), 32'd0);
        chk({tag, " ALUResultM"}, ALUResultM, 32'd0);
        chk({tag, " WriteDataM"}, WriteDataM, 32'd0);
        chk({tag, " PCPlus4M"}, PCPlus4M, 32'd0);
    endtask

    // Drive one D/E bundle on the falling edge and queue its hand-computed results
    task automatic op(input logic [2:0] ctl, input logic asrc, input logic br, input logic [1:0] rs,
                      input logic rw, input logic mw, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic [31:0] pc, input logic [31:0] pc4,
                      input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw_val,
                      input logic e_pcsrc, input logic [31:0] e_tgt,
                      input logic [31:0] e_alu, input logic [31:0] e_wd);
        exp_c_t c;
        exp_m_t m;
        @(negedge clk);
        ALUControlE = ctl; ALUSrcE = asrc; BranchE = br; ResultSrcE = rs;
        RegWriteE = rw; MemWriteE = mw; RD_E = rd;
        RD1_E = a; RD2_E = b; Imm_Ext_E = imm; PCE = pc; PCPlus4E = pc4;
        ForwardAE = fa; ForwardBE = fb; ResultW = rw_val;
        c.pcsrc = e_pcsrc; c.tgt = e_tgt;
        m.rw = rw; m.mw = mw; m.rs = rs; m.rd = rd; m.alu = e_alu; m.wd = e_wd; m.pc4 = pc4;
        cq.push_back(c);
        mq.push_back(m);
    endtask

    // Combinational monitor: outputs settled after the falling-edge drive
    initial forever begin
        exp_c_t c;
        @(negedge clk);
        #2;
        if (cq.size() != 0) begin
            c = cq.pop_front();
            chk("PCSrcE", 32'(PCSrcE), 32'(c.pcsrc));
            chk("PCTargetE", PCTargetE, c.tgt);
        end
    end

    // Registered monitor: E/M outputs one edge after the drive
    initial forever begin
        exp_m_t m;
        @(posedge clk);
        #1;
        if (mq.size() != 0) begin
            m = mq.pop_front();
            chk("RegWriteM", 32'(RegWriteM), 32'(m.rw));
            chk("MemWriteM", 32'(MemWriteM), 32'(m.mw));
            chk("ResultSrcM", 32'(ResultSrcM), 32'(m.rs));
            chk("RD_M", 32'(RD_M), 32'(m.rd));
            chk("ALUResultM", ALUResultM, m.alu);
            chk("WriteDataM", WriteDataM, m.wd);
            chk("PCPlus4M", PCPlus4M, m.pc4);
        end
    end

    initial begin
        rst = 1'b1;
        {RegWriteE, ALUSrcE, MemWriteE, BranchE} = '0;
        ALUControlE = '0; ResultSrcE = '0; ForwardAE = '0; ForwardBE = '0;
        RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; PCE = '0; PCPlus4E = '0; ResultW = '0; RD_E = '0;
        #2 rst = 1'b0;
        #1;
        chk_m_zero("reset");
        chk("reset PCSrcE", 32'(PCSrcE), 32'd0);
        chk("reset PCTargetE", PCTargetE, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // ctl  src br rs    rw mw rd  a             b             imm           pc            pc4          fa     fb     rW        pcsrc tgt           alu           wd
        op(3'd0, 0, 0, 2'b00, 1, 1, 5'd3, 32'd5,       32'd7,       32'd0,       32'd0,       32'd4,       2'b00, 2'b00, 32'd0,    0, 32'd0,       32'd12,       32'd7);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_m_zero("async reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        op(3'd0, 0, 0, 2'b00, 1, 0, 5'd3, 32'd5,       32'd7,       32'd0,       32'd0,       32'd4,       2'b00, 2'b00, 32'd0,    0, 32'd0,       32'd12,       32'd7);
        op(3'd0, 0, 0, 2'b00, 1, 0, 5'd5, 32'd40,      32'd60,      32'd0,       32'd0,       32'd8,       2'b00, 2'b00, 32'd0,    0, 32'd0,       32'd100,      32'd60);
        op(3'd0, 1, 0, 2'b00, 1, 0, 5'd6, 32'd1,       32'd0,       32'd4,       32'd0,       32'd12,      2'b10, 2'b00, 32'd0,    0, 32'd4,       32'd104,      32'd0);
        op(3'd0, 1, 0, 2'b00, 0, 1, 5'd0, 32'h1000,    32'd0,       32'd8,       32'd0,       32'd16,      2'b00, 2'b01, 32'hDEAD, 0, 32'd8,       32'h1008,     32'hDEAD);
        op(3'd1, 0, 1, 2'b00, 0, 0, 5'd0, 32'd9,       32'd9,       32'hFFFFFFF8,32'h40,      32'h44,      2'b00, 2'b00, 32'd0,    1, 32'h38,      32'd0,        32'd9);
        op(3'd1, 0, 1, 2'b00, 0, 0, 5'd0, 32'd9,       32'd8,       32'hFFFFFFF8,32'h40,      32'h44,      2'b00, 2'b00, 32'd0,    0, 32'h38,      32'd1,        32'd8);
        op(3'd0, 0, 0, 2'b10, 1, 0, 5'd1, 32'd0,       32'd0,       32'h20,      32'h100,     32'h104,     2'b00, 2'b00, 32'd0,    1, 32'h120,     32'd0,        32'd0);
        op(3'd5, 1, 0, 2'b00, 1, 0, 5'd7, 32'hFFFFFFFF,32'd0,       32'd1,       32'd0,       32'd4,       2'b00, 2'b00, 32'd0,    0, 32'd1,       32'd1,        32'd0);
        op(3'd6, 1, 0, 2'b00, 1, 0, 5'd7, 32'hFFFFFFFF,32'd0,       32'd1,       32'd0,       32'd4,       2'b00, 2'b00, 32'd0,    0, 32'd1,       32'd0,        32'd0);
        op(3'd7, 1, 0, 2'b00, 1, 0, 5'd8, 32'd1,       32'd0,       32'h21,      32'd0,       32'd4,       2'b00, 2'b00, 32'd0,    0, 32'h21,      32'd2,        32'd0);
        op(3'd0, 0, 0, 2'b00, 1, 0, 5'd9, 32'h7FFFFFFF,32'd1,       32'd8,       32'hFFFFFFFC,32'd0,       2'b00, 2'b00, 32'd0,    0, 32'd4,       32'h80000000, 32'd1);
        op(3'd0, 1, 0, 2'b00, 1, 1, 5'd0, 32'd3,       32'd9,       32'd2,       32'd0,       32'd4,       2'b11, 2'b10, 32'd77,   0, 32'd2,       32'd5,        32'h80000000);
        op(3'd2, 0, 0, 2'b00, 1, 0, 5'd10,32'hF0F0,    32'hFF00,    32'd0,       32'd0,       32'd4,       2'b00, 2'b00, 32'd0,    0, 32'd0,       32'hF000,     32'hFF00);
        op(3'd3, 0, 0, 2'b00, 1, 0, 5'd11,32'hF0F0,    32'hFF00,    32'd0,       32'd0,       32'd4,       2'b00, 2'b00, 32'd0,    0, 32'd0,       32'hFFF0,     32'hFF00);
        op(3'd4, 0, 0, 2'b00, 1, 0, 5'd12,32'hF0F0,    32'hFF00,    32'd0,       32'd0,       32'd4,       2'b00, 2'b00, 32'd0,    0, 32'd0,       32'h0FF0,     32'hFF00);
        op(3'd1, 0, 1, 2'b00, 0, 0, 5'd0, 32'd1,       32'd5,       32'h10,      32'h200,     32'h204,     2'b01, 2'b00, 32'd5,    1, 32'h210,     32'd0,        32'd5);
        repeat (3) @(negedge clk);
        compared++;
        if (cq.size() != 0 || mq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0/0", cq.size(), mq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
